// File: rtl/ddr3_wr_packer.sv
// Write-side pixel packer for the DDR3 frame path: packs PIX_W pixels into DDR_W words with lane
// masks, partial-word flush, a one-word valid/ready output stage and a frame-start FIFO reset pulse.
module ddr3_wr_packer #(
    parameter int PIX_W     = 16,
    parameter int DDR_W     = 256,
    parameter int MSB_FIRST = 1,
    parameter int RST_LEN   = 16
) (
    input  logic                     wr_clk,
    input  logic                     rst_n,
    input  logic                     wr_load,
    input  logic                     datain_valid,
    input  logic [PIX_W-1:0]         datain,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DDR_W-1:0]         out_data,
    output logic [DDR_W/PIX_W-1:0]   out_mask,
    output logic                     fifo_rst,
    output logic [15:0]              drop_cnt
);
    localparam int N     = DDR_W / PIX_W;
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(N + 1);
    localparam int RC_W  = $clog2(RST_LEN);

    typedef enum logic [1:0] {FILL, FULL, RSTP} state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [IDX_W-1:0] lane_of(input logic [CNT_W-1:0] cnt);
        return (MSB_FIRST != 0) ? IDX_W'(N - 1 - int'(cnt)) : IDX_W'(int'(cnt));
    endfunction

    function automatic logic [N-1:0] lane_mask(input logic [CNT_W-1:0] cnt);
        logic [N-1:0] m;
        m = '0;
        for (int k = 0; k < N; k++) begin
            if (MSB_FIRST != 0) m[k] = (k >= N - int'(cnt));
            else                m[k] = (k < int'(cnt));
        end
        return m;
    endfunction

    logic              ld_s1_q, ld_s2_q, ld_s3_q;
    logic              load_edge;
    state_e            state_q, state_d;
    logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [DDR_W-1:0]  lanes_q, lanes_d, lanes_w;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_w;
    logic              fp_q, fp_d, fp_w;
    logic              ov_q, ov_d;
    logic [DDR_W-1:0]  od_q, od_d;
    logic [N-1:0]      om_q, om_d;
    logic [15:0]       drop_q, drop_d;
    logic              free_w, req_w;

    // Two-flop synchroniser on the frame sync level, third flop for rising-edge detect
    assign load_edge = ld_s2_q & ~ld_s3_q;

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        lanes_d   = lanes_q;
        cnt_d     = cnt_q;
        fp_d      = fp_q;
        ov_d      = ov_q;
        od_d      = od_q;
        om_d      = om_q;
        drop_d    = drop_q;
        lanes_w   = lanes_q;
        cnt_w     = cnt_q;
        fp_w      = fp_q;
        free_w    = !ov_q || out_ready;
        req_w     = 1'b0;

        if (load_edge || state_q == RSTP) begin
            lanes_d = '0;
            cnt_d   = '0;
            fp_d    = 1'b0;
            ov_d    = 1'b0;
            od_d    = '0;
            om_d    = '0;
            drop_d  = '0;
            if (load_edge) begin
                state_d   = RSTP;
                rst_cnt_d = RC_W'(RST_LEN - 1);
            end else if (rst_cnt_q == '0) begin
                state_d = FILL;
            end else begin
                rst_cnt_d = rst_cnt_q - RC_W'(1);
            end
        end else begin
            if (ov_q && out_ready) ov_d = 1'b0;

            // A held full word moves out first so a pixel on this edge lands in the emptied register
            if (cnt_w == CNT_W'(N) && free_w) begin
                ov_d    = 1'b1;
                od_d    = lanes_w;
                om_d    = lane_mask(cnt_w);
                lanes_w = '0;
                cnt_w   = '0;
                fp_w    = 1'b0;
                free_w  = 1'b0;
            end

            if (datain_valid) begin
                if (cnt_w < CNT_W'(N)) begin
                    lanes_w[lane_of(cnt_w)*PIX_W +: PIX_W] = datain;
                    cnt_w = cnt_w + CNT_W'(1);
                end else begin
                    drop_d = sat_inc16(drop_q);
                end
            end

            req_w = (cnt_w == CNT_W'(N)) || ((flush || fp_w) && cnt_w != '0);
            if (req_w) begin
                if (free_w) begin
                    ov_d    = 1'b1;
                    od_d    = lanes_w;
                    om_d    = lane_mask(cnt_w);
                    lanes_w = '0;
                    cnt_w   = '0;
                    fp_w    = 1'b0;
                end else begin
                    // A full word is emitted anyway; only a partial word needs the pending flag
                    fp_w = (cnt_w != CNT_W'(N));
                end
            end

            lanes_d = lanes_w;
            cnt_d   = cnt_w;
            fp_d    = fp_w;
            state_d = (cnt_w == CNT_W'(N)) ? FULL : FILL;
        end
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_s1_q   <= 1'b0;
            ld_s2_q   <= 1'b0;
            ld_s3_q   <= 1'b0;
            state_q   <= FILL;
            rst_cnt_q <= '0;
            lanes_q   <= '0;
            cnt_q     <= '0;
            fp_q      <= 1'b0;
            ov_q      <= 1'b0;
            od_q      <= '0;
            om_q      <= '0;
            drop_q    <= '0;
        end else begin
            ld_s1_q   <= wr_load;
            ld_s2_q   <= ld_s1_q;
            ld_s3_q   <= ld_s2_q;
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            lanes_q   <= lanes_d;
            cnt_q     <= cnt_d;
            fp_q      <= fp_d;
            ov_q      <= ov_d;
            od_q      <= od_d;
            om_q      <= om_d;
            drop_q    <= drop_d;
        end
    end

    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign out_mask  = om_q;
    assign fifo_rst  = (state_q == RSTP);
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_ddr3_wr_packer.sv
// Bench for ddr3_wr_packer: directed scenarios plus randomized traffic against a pixel-queue model.
module tb_ddr3_wr_packer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, wr_load, dv, flush, ready;
    logic [15:0]  din;
    logic         ov, frst;
    logic [255:0] od;
    logic [15:0]  om, drop;

    logic         d5_load, d5_valid, d5_flush, d5_ready;
    logic [31:0]  d5_din;
    logic         d5_ov, d5_frst;
    logic [127:0] d5_od;
    logic [3:0]   d5_om;
    logic [15:0]  d5_drop;

    int n_checks = 0;
    int n_err    = 0;

    ddr3_wr_packer dut (
        .wr_clk(clk), .rst_n(rst_n), .wr_load(wr_load), .datain_valid(dv), .datain(din),
        .flush(flush), .out_valid(ov), .out_ready(ready), .out_data(od), .out_mask(om),
        .fifo_rst(frst), .drop_cnt(drop)
    );

    ddr3_wr_packer #(.PIX_W(32), .DDR_W(128), .MSB_FIRST(0), .RST_LEN(16)) dut5 (
        .wr_clk(clk), .rst_n(rst_n), .wr_load(d5_load), .datain_valid(d5_valid), .datain(d5_din),
        .flush(d5_flush), .out_valid(d5_ov), .out_ready(d5_ready), .out_data(d5_od), .out_mask(d5_om),
        .fifo_rst(d5_frst), .drop_cnt(d5_drop)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected packing for the default instance: pixel j of a word sits in lane 15-j
    function automatic logic [255:0] word16(input logic [15:0] q[$]);
        logic [255:0] w;
        w = '0;
        for (int j = 0; j < q.size(); j++) w[(15-j)*16 +: 16] = q[j];
        return w;
    endfunction

    function automatic logic [15:0] msk16(input int n);
        logic [15:0] m;
        m = '0;
        for (int j = 0; j < n; j++) m[15-j] = 1'b1;
        return m;
    endfunction

    logic [15:0]  q[$];
    logic [15:0]  q2[$];
    logic [15:0]  mq[$];
    bit           m_busy, m_fp, fr;
    logic [255:0] m_word;
    logic [15:0]  m_mask;
    int           m_drop, hi;
    bit           ovseen;

    initial begin
        rst_n = 1'b0; wr_load = 1'b0; dv = 1'b0; flush = 1'b0; ready = 1'b1; din = '0;
        d5_load = 1'b0; d5_valid = 1'b0; d5_flush = 1'b0; d5_ready = 1'b1; d5_din = '0;
        tick(); tick();
        chk("rst_ov", 256'(ov), 256'(0));
        chk("rst_data", od, 256'(0));
        chk("rst_mask", 256'(om), 256'(0));
        chk("rst_fifo_rst", 256'(frst), 256'(0));
        chk("rst_drop", 256'(drop), 256'(0));
        rst_n = 1'b1;
        tick();

        // Full word, MSB-first lanes, single-cycle valid with ready high
        q.delete();
        for (int i = 1; i <= 16; i++) begin
            dv = 1'b1; din = 16'(i); q.push_back(16'(i));
            tick();
            if (i == 15) chk("t1_ov_early", 256'(ov), 256'(0));
        end
        dv = 1'b0;
        chk("t1_ov", 256'(ov), 256'(1));
        chk("t1_data", od, word16(q));
        chk("t1_lane15", 256'(od[255:240]), 256'(16'h0001));
        chk("t1_mask", 256'(om), 256'(16'hFFFF));
        tick();
        chk("t1_ov_one_cycle", 256'(ov), 256'(0));

        // Narrow-lane instance, LSB-first
        for (int k = 1; k <= 4; k++) begin
            d5_valid = 1'b1; d5_din = 32'h11111111 * 32'(k);
            tick();
        end
        d5_valid = 1'b0;
        chk("t5_ov", 256'(d5_ov), 256'(1));
        chk("t5_data", 256'(d5_od), 256'({32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}));
        chk("t5_mask", 256'(d5_om), 256'(4'hF));
        chk("t5_fifo_rst", 256'(d5_frst), 256'(0));
        chk("t5_drop", 256'(d5_drop), 256'(0));
        tick();

        // Back-pressure: second word waits full, 33rd pixel dropped
        ready = 1'b0; q.delete(); q2.delete();
        for (int i = 0; i < 33; i++) begin
            dv = 1'b1; din = 16'h0100 + 16'(i);
            if (i < 16) q.push_back(din); else if (i < 32) q2.push_back(din);
            tick();
            if (i == 15) chk("t2_w1_first", od, word16(q));
        end
        dv = 1'b0;
        chk("t2_ov_held", 256'(ov), 256'(1));
        chk("t2_w1_stable", od, word16(q));
        chk("t2_drop", 256'(drop), 256'(1));
        ready = 1'b1;
        tick();
        chk("t2_w2_ov", 256'(ov), 256'(1));
        chk("t2_w2_data", od, word16(q2));
        chk("t2_w2_mask", 256'(om), 256'(16'hFFFF));
        tick();
        chk("t2_ov_done", 256'(ov), 256'(0));

        // Partial word flush
        q.delete();
        for (int i = 0; i < 5; i++) begin
            dv = 1'b1; din = 16'h00A0 + 16'(i); q.push_back(din);
            tick();
        end
        dv = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t3_ov", 256'(ov), 256'(1));
        chk("t3_data", od, word16(q));
        chk("t3_mask", 256'(om), 256'(16'hF800));
        tick();
        chk("t3_ov_done", 256'(ov), 256'(0));

        // Flush on empty register, then flush coinciding with the 16th pixel
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t6_empty_flush", 256'(ov), 256'(0));
        tick();
        chk("t6_empty_flush2", 256'(ov), 256'(0));
        q.delete();
        for (int i = 0; i < 16; i++) begin
            dv = 1'b1; din = 16'h0C00 + 16'(i); q.push_back(din);
            flush = (i == 15);
            tick();
            if (i == 14) chk("t6_ov_early", 256'(ov), 256'(0));
        end
        dv = 1'b0; flush = 1'b0;
        chk("t6_ov", 256'(ov), 256'(1));
        chk("t6_data", od, word16(q));
        chk("t6_mask", 256'(om), 256'(16'hFFFF));
        tick();
        q.delete();
        for (int i = 0; i < 16; i++) begin
            dv = 1'b1; din = 16'h0D00 + 16'(i); q.push_back(din);
            tick();
            if (i == 14) chk("t6_cnt0_early", 256'(ov), 256'(0));
        end
        dv = 1'b0;
        chk("t6_cnt0_word", od, word16(q));
        chk("t6_cnt0_ov", 256'(ov), 256'(1));
        tick();

        // Frame start mid-word
        for (int i = 0; i < 7; i++) begin
            dv = 1'b1; din = 16'h0E00 + 16'(i);
            tick();
        end
        wr_load = 1'b1; hi = 0; ovseen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            din = 16'($urandom);
            tick();
            if (c == 1) chk("t4_fifo_rst_pre", 256'(frst), 256'(0));
            if (c == 2) chk("t4_fifo_rst_start", 256'(frst), 256'(1));
            if (ov) ovseen = 1'b1;
            if (frst) hi++;
            else if (hi > 0) break;
        end
        dv = 1'b0;
        chk("t4_pulse_len", 256'(hi), 256'(16));
        chk("t4_no_partial", 256'(ovseen), 256'(0));
        chk("t4_drop_clr", 256'(drop), 256'(0));
        q.delete();
        for (int i = 0; i < 16; i++) begin
            dv = 1'b1; din = 16'h0F00 + 16'(i); q.push_back(din);
            tick();
        end
        dv = 1'b0;
        chk("t4_clean_ov", 256'(ov), 256'(1));
        chk("t4_clean_data", od, word16(q));
        tick();

        // Randomized traffic against the pixel-queue model
        mq.delete(); m_busy = 1'b0; m_fp = 1'b0; m_drop = 0; m_word = '0; m_mask = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            dv    = ($urandom_range(0, 3) != 0);
            din   = 16'($urandom);
            flush = ($urandom_range(0, 15) == 0);
            ready = ($urandom_range(0, 2) != 0);
            tick();
            fr = !m_busy || ready;
            if (m_busy && ready) m_busy = 1'b0;
            if (mq.size() == 16 && fr) begin
                m_word = word16(mq); m_mask = msk16(16); mq.delete();
                m_busy = 1'b1; fr = 1'b0; m_fp = 1'b0;
            end
            if (dv) begin
                if (mq.size() < 16) mq.push_back(din);
                else if (m_drop < 65535) m_drop++;
            end
            if (mq.size() == 16 || ((flush || m_fp) && mq.size() > 0)) begin
                if (fr) begin
                    m_word = word16(mq); m_mask = msk16(mq.size()); mq.delete();
                    m_busy = 1'b1; m_fp = 1'b0;
                end else begin
                    m_fp = (mq.size() < 16);
                end
            end
            chk("rnd_ov", 256'(ov), 256'(m_busy));
            if (m_busy) begin
                chk("rnd_data", od, m_word);
                chk("rnd_mask", 256'(om), 256'(m_mask));
            end
            chk("rnd_drop", 256'(drop), 256'(m_drop));
        end
        dv = 1'b0; flush = 1'b0; ready = 1'b1; wr_load = 1'b0;
        tick(); tick(); tick(); tick();

        // Asynchronous reset mid-word discards the partial word
        for (int i = 0; i < 5; i++) begin
            dv = 1'b1; din = 16'h0B00 + 16'(i);
            tick();
        end
        dv = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("arst_ov", 256'(ov), 256'(0));
        chk("arst_mask", 256'(om), 256'(0));
        chk("arst_drop", 256'(drop), 256'(0));
        rst_n = 1'b1;
        tick();
        q.delete();
        for (int i = 0; i < 16; i++) begin
            dv = 1'b1; din = 16'h0700 + 16'(i); q.push_back(din);
            tick();
        end
        dv = 1'b0;
        chk("arst_clean_ov", 256'(ov), 256'(1));
        chk("arst_clean_data", od, word16(q));
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
